// File: rtl/store_data_unit.sv
// Store data unit: aligns SB/SH/SW store data onto a 32-bit Avalon-MM write port
// and rejects misaligned or reserved store types with a one-cycle pulse.
module store_data_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        ready,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    output logic [15:0] store_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] address_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [15:0] count_q;

    logic        legal;
    logic [31:0] wdata_n;
    logic [3:0]  be_n;
    logic        accept;
    logic        write_end;

    // Lane steering and alignment check, evaluated on the live request inputs.
    always_comb begin
        legal   = 1'b0;
        wdata_n = 32'h0;
        be_n    = 4'b0000;
        case (op)
            2'b00: begin
                legal   = 1'b1;
                wdata_n = {4{data[7:0]}};
                be_n    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                legal   = ~addr[0];
                wdata_n = {2{data[15:0]}};
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal   = (addr[1:0] == 2'b00);
                wdata_n = data;
                be_n    = 4'b1111;
            end
            default: begin
                legal   = 1'b0;
            end
        endcase
    end

    assign accept    = (state_q == IDLE) && req;
    assign write_end = (state_q == WRITE) && !avm_waitrequest;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = legal ? WRITE : ERR;
            WRITE:   if (!avm_waitrequest) state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus registers are loaded on a legal accept and cleared when the write
    // completes, so they read zero everywhere outside WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            address_q <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'b0000;
            count_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept && legal) begin
                address_q <= {addr[31:2], 2'b00};
                wdata_q   <= wdata_n;
                be_q      <= be_n;
            end else if (write_end) begin
                address_q <= 32'h0;
                wdata_q   <= 32'h0;
                be_q      <= 4'b0000;
            end
            if (write_end) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign ready          = (state_q == IDLE);
    assign done           = (state_q == DONE);
    assign misaligned     = (state_q == ERR);
    assign avm_write      = (state_q == WRITE);
    assign avm_address    = address_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign store_count    = count_q;

endmodule

// File: tb/tb_store_data_unit.sv
// Directed self-checking bench for store_data_unit: lane steering, wait states,
// misalignment rejection, asynchronous reset mid-write and store_count wrap.
module tb_store_data_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        done;
    logic        misaligned;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [15:0] store_count;

    int n_cmp = 0;
    int n_err = 0;

    store_data_unit dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .op              (op),
        .addr            (addr),
        .data            (data),
        .ready           (ready),
        .done            (done),
        .misaligned      (misaligned),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .store_count     (store_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        req  = 1'b1;
        op   = o;
        addr = a;
        data = d;
        @(negedge clk);
        req  = 1'b0;
    endtask

    logic [1:0]  bad_op   [3];
    logic [31:0] bad_addr [3];
    logic [15:0] cnt_before;
    int          done_seen;

    initial begin
        bad_op[0] = 2'b01; bad_addr[0] = 32'h0000_4001;
        bad_op[1] = 2'b10; bad_addr[1] = 32'h0000_4002;
        bad_op[2] = 2'b11; bad_addr[2] = 32'h0000_4000;

        reset = 1'b1; req = 1'b0; op = 2'b00; addr = 32'h0; data = 32'h0;
        avm_waitrequest = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_count", 32'(store_count), 32'd0);
        check("rst_be", 32'(avm_byteenable), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // SW, zero wait states
        issue(2'b10, 32'h0000_1004, 32'hDEAD_BEEF);
        check("sw_write", 32'(avm_write), 32'd1);
        check("sw_ready", 32'(ready), 32'd0);
        check("sw_addr", avm_address, 32'h0000_1004);
        check("sw_be", 32'(avm_byteenable), 32'hF);
        check("sw_wdata", avm_writedata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_done", 32'(done), 32'd1);
        check("sw_write_off", 32'(avm_write), 32'd0);
        check("sw_wdata_off", avm_writedata, 32'h0);
        check("sw_count", 32'(store_count), 32'd1);
        @(negedge clk);
        check("sw_done_off", 32'(done), 32'd0);
        check("sw_ready_back", 32'(ready), 32'd1);

        // SB to byte 3
        issue(2'b00, 32'h0000_2003, 32'h1234_56AB);
        check("sb_be", 32'(avm_byteenable), 32'h8);
        check("sb_wdata", avm_writedata, 32'hABAB_ABAB);
        check("sb_addr", avm_address, 32'h0000_2000);
        @(negedge clk);
        check("sb_count", 32'(store_count), 32'd2);
        @(negedge clk);

        // SH, upper half, three wait states; inputs scrambled during WRITE
        avm_waitrequest = 1'b1;
        done_seen = 0;
        issue(2'b01, 32'h0000_3002, 32'h0000_CAFE);
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; op = 2'b10; addr = 32'hFFFF_FFF0 + 32'(i); data = 32'h5555_0000;
            check("sh_write", 32'(avm_write), 32'd1);
            check("sh_be", 32'(avm_byteenable), 32'hC);
            check("sh_wdata", avm_writedata, 32'hCAFE_CAFE);
            check("sh_addr", avm_address, 32'h0000_3000);
            if (done) done_seen++;
            if (i == 3) avm_waitrequest = 1'b0;
            @(negedge clk);
        end
        req = 1'b0;
        check("sh_done", 32'(done), 32'd1);
        check("sh_count", 32'(store_count), 32'd3);
        @(negedge clk);
        if (done) done_seen++;
        check("sh_extra_done", 32'(done_seen), 32'd0);
        check("sh_ready_back", 32'(ready), 32'd1);

        // Rejected requests
        for (int i = 0; i < 3; i++) begin
            cnt_before = store_count;
            issue(bad_op[i], bad_addr[i], 32'hFFFF_FFFF);
            check("mis_pulse", 32'(misaligned), 32'd1);
            check("mis_write", 32'(avm_write), 32'd0);
            check("mis_be", 32'(avm_byteenable), 32'd0);
            @(negedge clk);
            check("mis_pulse_off", 32'(misaligned), 32'd0);
            check("mis_write2", 32'(avm_write), 32'd0);
            check("mis_ready", 32'(ready), 32'd1);
            check("mis_count", 32'(store_count), 32'(cnt_before));
        end

        // Reset asserted mid-cycle during a stalled write
        avm_waitrequest = 1'b1;
        issue(2'b10, 32'h0000_5000, 32'h0BAD_F00D);
        check("rw_write_pre", 32'(avm_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rw_write_drop", 32'(avm_write), 32'd0);
        check("rw_ready", 32'(ready), 32'd1);
        check("rw_done", 32'(done), 32'd0);
        check("rw_count", 32'(store_count), 32'd0);
        check("rw_wdata", avm_writedata, 32'h0);
        @(negedge clk);
        check("rw_done_hold", 32'(done), 32'd0);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        issue(2'b00, 32'h0000_6001, 32'h0000_0077);
        check("rw_accept", 32'(avm_write), 32'd1);
        check("rw_be", 32'(avm_byteenable), 32'h2);
        @(negedge clk);
        check("rw_done_after", 32'(done), 32'd1);
        check("rw_count_after", 32'(store_count), 32'd1);
        @(negedge clk);

        // Counter wrap: clear, then 65535 stores to reach FFFF, then one more
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            issue(2'b10, 32'h0000_8000, 32'(i));
            @(negedge clk);
            @(negedge clk);
        end
        check("wrap_pre", 32'(store_count), 32'h0000_FFFF);
        issue(2'b10, 32'h0000_8000, 32'h1);
        @(negedge clk);
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_count", 32'(store_count), 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_data_unit.md
STORE_DATA_UNIT -- requirements
Module: store_data_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port req, input, 1 bit: store request, sampled only while ready=1.
REQ-004 The block SHALL have the port op, input, 2 bits: store type; 00=SB, 01=SH, 10=SW, 11=reserved.
REQ-005 The block SHALL have the port addr, input, 32 bits: byte address of the store.
REQ-006 The block SHALL have the port data, input, 32 bits: rt register value to be stored.
REQ-007 The block SHALL have the port ready, output, 1 bit: block idle and able to accept req.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse when a bus write has completed.
REQ-009 The block SHALL have the port misaligned, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-010 The block SHALL have the port avm_address, output, 32 bits: word-aligned bus address.
REQ-011 The block SHALL have the port avm_write, output, 1 bit: bus write strobe.
REQ-012 The block SHALL have the port avm_writedata, output, 32 bits: lane-replicated write data.
REQ-013 The block SHALL have the port avm_byteenable, output, 4 bits: active byte lanes.
REQ-014 The block SHALL have the port avm_waitrequest, input, 1 bit: bus stall; the write is held while high.
REQ-015 The block SHALL have the port store_count, output, 16 bits: number of completed bus writes.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WRITE, DONE and ERR, and SHALL be in IDLE after reset.
REQ-017 ready SHALL be 1 in IDLE only; a request is accepted at a rising edge with req=1 and ready=1, and op/addr/data SHALL be latched at that edge.
REQ-018 Alignment check: SB is always legal; SH is legal only when addr[0]=0; SW is legal only when addr[1:0]=00; op=11 is always illegal.
REQ-019 A legal accepted request SHALL move the FSM IDLE->WRITE; an illegal one SHALL move it IDLE->ERR with no bus activity.
REQ-020 In WRITE, avm_write SHALL be 1 and all avm_* outputs SHALL be registered and held stable while avm_waitrequest=1.
REQ-021 WRITE->DONE SHALL occur at the first rising edge with avm_waitrequest=0; there SHALL be no timeout.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-023 In ERR, misaligned SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-024 Latency: a request accepted at edge N SHALL drive avm_write=1 in cycle N+1; with zero wait states, done SHALL be high in cycle N+2 and ready SHALL be high in cycle N+3.
REQ-025 avm_address SHALL be {addr[31:2],2'b00}.
REQ-026 Byte ordering SHALL be little-endian: byte lane k is writedata[8k+7:8k] for address offset k.
REQ-027 SB SHALL drive writedata={4{data[7:0]}} and byteenable=4'b0001<<addr[1:0].
REQ-028 SH SHALL drive writedata={2{data[15:0]}} and byteenable=0011 when addr[1]=0, 1100 when addr[1]=1.
REQ-029 SW SHALL drive writedata=data and byteenable=1111.
REQ-030 Outside WRITE, avm_write, avm_byteenable, avm_address and avm_writedata SHALL all be 0.
REQ-031 store_count SHALL increment by 1 on entry to DONE and wrap from FFFF to 0000; ERR SHALL NOT increment it.
REQ-032 req, op, addr and data SHALL be ignored whenever ready=0, and changes to them during WRITE SHALL NOT affect the avm_* outputs.

Reset
REQ-033 Asserting reset SHALL immediately, without waiting for a clock edge, force state=IDLE, ready=1, done=0, misaligned=0, all avm_* outputs to 0, and store_count=0.
REQ-034 Reset asserted mid-WRITE SHALL abandon the write with no done pulse; after reset is released, the next rising edge SHALL be able to accept a request.

Verification
REQ-035 The bench SHALL check that SW with addr=0x0000_1004, data=0xDEADBEEF and waitrequest=0 gives avm_address=0x1004, be=1111, writedata=DEADBEEF for one cycle, then done=1, then store_count=1.
REQ-036 The bench SHALL check that SB with addr=0x0000_2003 and data=0x123456AB gives be=1000, writedata=ABABABAB, avm_address=0x2000.
REQ-037 The bench SHALL check that SH with addr=0x0000_3002, data=0x0000CAFE and waitrequest held high for 3 cycles gives avm_write=1 with stable outputs for 4 cycles, be=1100, writedata=CAFECAFE, and a single done pulse.
REQ-038 The bench SHALL check that SH at addr=0x...1, SW at addr=0x...2 and op=11 each give misaligned=1 for one cycle, avm_write never 1, and store_count unchanged.
REQ-039 The bench SHALL check that reset asserted mid-cycle during WRITE with waitrequest=1 drops avm_write at once, gives no done pulse, store_count=0 and ready=1.
REQ-040 The bench SHALL check that preloading store_count to FFFF via 65535 stores, followed by one more store, wraps store_count to 0000.
